// File: rtl/gf3m_if.sv
// Start/busy/done handshake and operand/result bus of the GF(3^M) serial multiplier.
interface gf3m_if #(parameter int M = 97) ();
  logic           start;
  logic [2*M-1:0] a;
  logic [2*M-1:0] b;
  logic           busy;
  logic           done;
  logic [2*M-1:0] c;

  modport master (output start, a, b, input  busy, done, c);
  modport slave  (input  start, a, b, output busy, done, c);
endinterface

// File: rtl/gf3m_serial_mult.sv
// Digit-serial MSB-first Horner multiplier over GF(3^M), P = x^M + x^12 + 2.
// One multiplier digit per clock: acc <- acc*x mod P + b_i*a.

// One output digit of the Horner step: shifted digit + reduction feedback + b_i*a_j.
module gf3_digit_step (
  input  logic [1:0] sh,
  input  logic [1:0] fb,
  input  logic [1:0] bd,
  input  logic [1:0] ad,
  output logic [1:0] nd
);
  function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // 2'b11 is illegal on inputs and scales as zero.
  function automatic logic [1:0] mul3(input logic [1:0] s, input logic [1:0] d);
    logic [1:0] r;
    r = 2'd0;
    if (s == 2'd1 && d != 2'd3)      r = d;
    else if (s == 2'd2 && d == 2'd1) r = 2'd2;
    else if (s == 2'd2 && d == 2'd2) r = 2'd1;
    return r;
  endfunction

  assign nd = add3(add3(sh, fb), mul3(bd, ad));
endmodule

module gf3m_serial_mult #(
  parameter int M     = 97,
  parameter int CNT_W = 7
) (
  input  logic   clk,
  input  logic   reset_n,
  gf3m_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [2*M-1:0]     a_r, b_r, acc, acc_nx, c_r;
  logic [CNT_W-1:0]   cnt;
  logic               done_r;
  logic               ld;
  logic [1:0]         t, t2, bd;
  logic [CNT_W:0]     bidx;

  // Reduction by x^M = 2x^12 + 1: top digit t folds into digit 0 (+t) and digit 12 (+2t).
  assign t    = acc[2*M-1 -: 2];
  assign t2   = (t == 2'd1) ? 2'd2 : (t == 2'd2) ? 2'd1 : 2'd0;
  assign bidx = {cnt, 1'b0};
  assign bd   = b_r[bidx +: 2];

  for (genvar i = 0; i < M; i++) begin : g_dig
    logic [1:0] sh, fb;
    if (i == 0) begin : g_lo
      assign sh = 2'd0;
      assign fb = t;
    end else if (i == 12) begin : g_tap
      assign sh = acc[2*i-1 -: 2];
      assign fb = t2;
    end else begin : g_mid
      assign sh = acc[2*i-1 -: 2];
      assign fb = 2'd0;
    end
    gf3_digit_step u_step (
      .sh (sh),
      .fb (fb),
      .bd (bd),
      .ad (a_r[2*i +: 2]),
      .nd (acc_nx[2*i +: 2])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        ld       = 1'b1;
        state_nx = RUN;
      end
      RUN:  if (cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      c_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (ld) begin
        a_r <= bus.a;
        b_r <= bus.b;
        acc <= '0;
        cnt <= CNT_W'(M - 1);
      end else if (state == RUN) begin
        acc <= acc_nx;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == DONE) begin
        // Result and pulse are registered, so they appear as the FSM returns to IDLE.
        c_r    <= acc;
        done_r <= 1'b1;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.c    = c_r;
endmodule

// File: tb/tb_gf3m_serial_mult.sv
// Directed-vector bench for gf3m_serial_mult with a schoolbook-multiply reference model.
module tb_gf3m_serial_mult;
  localparam int M = 97;
  localparam int W = 2*M;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gf3m_if #(.M(M)) bus ();
  gf3m_serial_mult #(.M(M), .CNT_W(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   exp;
  } vec_t;

  function automatic logic [W-1:0] dig(input int p, input logic [1:0] v);
    logic [W-1:0] r;
    r = '0;
    r[2*p +: 2] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_elem();
    logic [W-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Full product then reduction from the top degree down: x^d = x^(d-97)*(2x^12 + 1).
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p [0:2*M-2];
    logic [W-1:0] r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        p[i+j] += int'(a[2*i +: 2]) * int'(b[2*j +: 2]);
    for (int d = 2*M-2; d >= M; d--) begin
      int v;
      v = p[d] % 3;
      p[d-M]      += v;
      p[d-M+12]   += 2*v;
      p[d] = 0;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issues one start; n counts negedges after the accepting edge (n=0 first RUN cycle).
  task automatic do_mult(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] oc, output int lat, output int bc);
    int n;
    lat = -1; bc = 0; n = 0;
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    forever begin
      if (bus.busy) bc++;
      if (bus.done) begin lat = n; break; end
      if (n >= 300) break;
      @(negedge clk);
      n++;
    end
    oc = bus.c;
  endtask

  vec_t vecs [8];
  logic [W-1:0] c, first_exp, ra [0:30], rb [0:30];
  int lat, bc, pulses, n, last_acc, cyc;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    cyc = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    vecs[0] = '{"one_one",   dig(0,2'd1),  dig(0,2'd1),  dig(0,2'd1)};
    vecs[1] = '{"x_x96",     dig(1,2'd1),  dig(96,2'd1), dig(12,2'd2) | dig(0,2'd1)};
    vecs[2] = '{"x96_x",     dig(96,2'd1), dig(1,2'd1),  dig(12,2'd2) | dig(0,2'd1)};
    vecs[3] = '{"two_two",   dig(0,2'd2),  dig(0,2'd2),  dig(0,2'd1)};
    vecs[4] = '{"zero_a",    '0,           rnd_elem(),   '0};
    vecs[5] = '{"zero_b",    rnd_elem(),   '0,           '0};
    vecs[6] = '{"x50_x50",   dig(50,2'd1), dig(50,2'd1), dig(15,2'd2) | dig(3,2'd1)};
    vecs[7] = '{"x96_x96",   dig(96,2'd1), dig(96,2'd1), dig(95,2'd1) | dig(22,2'd1) | dig(10,2'd2)};

    repeat (2) @(negedge clk);
    chki("rst_busy", int'(bus.busy), 0);
    chki("rst_done", int'(bus.done), 0);
    chk("rst_c", bus.c, '0);
    reset_n = 1'b1;

    do_mult(vecs[0].a, vecs[0].b, c, lat, bc);
    chki("done_latency", lat, M+1);
    chki("busy_cycles", bc, M+1);
    @(negedge clk);
    chki("done_one_cycle", int'(bus.done), 0);
    chk("c_held", bus.c, dig(0,2'd1));

    for (int i = 0; i < 8; i++) begin
      do_mult(vecs[i].a, vecs[i].b, c, lat, bc);
      chk(vecs[i].name, c, vecs[i].exp);
    end

    // Starts while busy must be ignored.
    first_exp = dig(0,2'd2) | dig(1,2'd1);
    @(negedge clk);
    bus.a = dig(0,2'd1) | dig(1,2'd2); bus.b = dig(0,2'd2); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; pulses = 0;
    for (n = 0; n < M+10; n++) begin
      if (n == 10) begin bus.start = 1'b1; bus.a = rnd_elem(); bus.b = rnd_elem(); end
      if (n == M) bus.start = 1'b0;
      if (bus.done) pulses++;
      @(negedge clk);
    end
    chki("ignored_pulses", pulses, 1);
    chk("ignored_c", bus.c, first_exp);

    // Reset in the middle of RUN discards the partial product.
    @(negedge clk);
    bus.a = dig(5,2'd1); bus.b = dig(7,2'd2); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chki("midrst_busy", int'(bus.busy), 0);
    chk("midrst_c", bus.c, '0);
    pulses = 0;
    repeat (M+5) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    chki("midrst_no_done", pulses, 0);
    do_mult(dig(5,2'd1), dig(7,2'd2), c, lat, bc);
    chk("midrst_fresh", c, dig(12,2'd2));

    // Back-to-back random operands with start held high.
    for (int i = 0; i <= 30; i++) begin ra[i] = rnd_elem(); rb[i] = rnd_elem(); end
    @(negedge clk);
    bus.a = ra[0]; bus.b = rb[0]; bus.start = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 30; i++) begin
      n = 0;
      while (!bus.busy && n < 20) begin @(negedge clk); n++; end
      if (!bus.busy) begin
        chki("b2b_accept_timeout", 0, 1);
        break;
      end
      if (i > 0) chki("b2b_interval", cyc - last_acc, M+2);
      last_acc = cyc;
      bus.a = ra[i+1]; bus.b = rb[i+1];
      n = 0;
      while (!bus.done && n < 300) begin @(negedge clk); n++; end
      chk("b2b_c", bus.c, ref_mul(ra[i], rb[i]));
      @(negedge clk);
    end
    bus.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
